// File: rtl/seq_pkg.sv
// Shared types and constants for the datapath sequencer.
// Optional feature macro: SEQ_RETIRE_CNT_EN (retired-instruction counter).
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ILLEGAL,
    C_ECALL,
    C_ADDI,
    C_ADD,
    C_BEQ,
    C_BNE
  } iclass_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  // B-type immediate, LSB always zero
  function automatic logic [12:0] b_imm(input logic [31:0] ir);
    return {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decoder for the sequencer.
// Classifies IR and extracts register fields and immediates.
module seq_decoder
  import seq_pkg::*;
(
  input  logic [31:0] ir_i,
  output iclass_e     cls_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [11:0] imm_i_o,
  output logic [12:0] imm_b_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_ecall;
  logic       is_addi;
  logic       is_add;
  logic       is_beq;
  logic       is_bne;

  assign opc = ir_i[6:0];
  assign f3  = ir_i[14:12];
  assign f7  = ir_i[31:25];

  assign is_ecall = (ir_i == ECALL);
  assign is_addi  = (opc == OP_IMM) && (f3 == F3_ADDI);
  assign is_add   = (opc == OP) && (f3 == F3_ADD)
                    && (f7 == F7_ADD);
  assign is_beq   = (opc == BRANCH) && (f3 == F3_BEQ);
  assign is_bne   = (opc == BRANCH) && (f3 == F3_BNE);

  assign rs1_o   = ir_i[19:15];
  assign rs2_o   = ir_i[24:20];
  assign rd_o    = ir_i[11:7];
  assign imm_i_o = ir_i[31:20];
  assign imm_b_o = b_imm(ir_i);

  // one-hot class select; anything unrecognised is illegal
  always_comb begin
    cls_o = C_ILLEGAL;
    unique case (1'b1)
      is_ecall: cls_o = C_ECALL;
      is_addi:  cls_o = C_ADDI;
      is_add:   cls_o = C_ADD;
      is_beq:   cls_o = C_BEQ;
      is_bne:   cls_o = C_BNE;
      default:  cls_o = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for a tiny RV32 subset.
// Optional: define SEQ_RETIRE_CNT_EN to add the instret counter port.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = 5,
  parameter int DATA_WIDTH         = 32,
  parameter int IMM_LENGTH         = 12,
  parameter int ALU_CONTROL_LENGTH = 3,
  parameter int PC_WIDTH           = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          imem_req,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic                          imem_ack,
  input  logic [DATA_WIDTH-1:0]         imem_data,
  output logic [ADDRESS_WIDTH-1:0]      AD1,
  output logic [ADDRESS_WIDTH-1:0]      AD2,
  output logic [ADDRESS_WIDTH-1:0]      AD3,
  output logic                          WE3,
  output logic                          ALUsrc,
  output logic [IMM_LENGTH-1:0]         ImmOP,
  output logic [ALU_CONTROL_LENGTH-1:0] ALUCtrl,
  input  logic                          EQ,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]                   instret
`endif
);

  state_e                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic                  illegal_q;

  iclass_e               cls;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [4:0]            rd;
  logic [11:0]           imm_i;
  logic [12:0]           imm_b;
  logic [PC_WIDTH-1:0]   b_off;
  logic                  taken;

  seq_decoder u_dec (
    .ir_i    (ir_q[31:0]),
    .cls_o   (cls),
    .rs1_o   (rs1),
    .rs2_o   (rs2),
    .rd_o    (rd),
    .imm_i_o (imm_i),
    .imm_b_o (imm_b)
  );

  assign b_off = PC_WIDTH'($signed(imm_b));
  assign taken = ((cls == C_BEQ) && EQ)
                 || ((cls == C_BNE) && !EQ);

  // next PC at the end of EXEC; wraps naturally
  always_comb begin
    pc_d = pc_q + PC_WIDTH'(4);
    if (taken) begin
      pc_d = pc_q + b_off;
    end
  end

  // sequencer FSM with PC, IR and halt-cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_data;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (cls)
            C_ECALL: begin
              illegal_q <= 1'b0;
              state_q   <= S_HALT;
            end
            C_ILLEGAL: begin
              illegal_q <= 1'b1;
              state_q   <= S_HALT;
            end
            default: state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          pc_q    <= pc_d;
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from state and IR only
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
    busy      = (state_q == S_FETCH)
                || (state_q == S_DECODE)
                || (state_q == S_EXEC);
    halted    = (state_q == S_HALT);
    illegal   = illegal_q;
    AD1       = '0;
    AD2       = '0;
    AD3       = '0;
    WE3       = 1'b0;
    ALUsrc    = 1'b0;
    ImmOP     = '0;
    ALUCtrl   = '0;
    if (state_q == S_EXEC) begin
      AD1 = ADDRESS_WIDTH'(rs1);
      AD2 = ADDRESS_WIDTH'(rs2);
      unique case (1'b1)
        (cls == C_ADDI): begin
          AD3     = ADDRESS_WIDTH'(rd);
          WE3     = (rd != 5'd0);
          ALUsrc  = 1'b1;
          ImmOP   = IMM_LENGTH'(imm_i);
          ALUCtrl = ALU_CONTROL_LENGTH'(ALU_ADD);
        end
        (cls == C_ADD): begin
          AD3     = ADDRESS_WIDTH'(rd);
          WE3     = (rd != 5'd0);
          ALUCtrl = ALU_CONTROL_LENGTH'(ALU_ADD);
        end
        (cls == C_BEQ),
        (cls == C_BNE): begin
          ALUCtrl = ALU_CONTROL_LENGTH'(ALU_SUB);
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] instret_q;

  // count every completed EXEC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (state_q == S_EXEC) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: directed and random programs.
// Define SEQ_RETIRE_CNT_EN to also check instret.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3, ALUsrc;
  logic [11:0] ImmOP;
  logic [2:0]  ALUCtrl;
  logic        EQ;
  logic        busy, halted, illegal;
`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] instret;
`endif

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .AD1       (AD1),
    .AD2       (AD2),
    .AD3       (AD3),
    .WE3       (WE3),
    .ALUsrc    (ALUsrc),
    .ImmOP     (ImmOP),
    .ALUCtrl   (ALUCtrl),
    .EQ        (EQ),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .instret   (instret)
`endif
  );

  typedef struct packed {
    logic [31:0] ins;
    logic        eq;
    logic [3:0]  dly;
    logic        hang;
  } prog_t;

  typedef struct {
    logic        halts;
    logic        ill;
    logic [31:0] vec;
  } exp_t;

  prog_t       prog_q[$];
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model_pc;
  int          exp_ret;
  logic        we3_seen;

  task automatic check(input string name,
                       input logic [95:0] act,
                       input logic [95:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // instruction-level reference: expected EXEC view and next PC
  function automatic void ref_model(input logic [31:0] ins,
                                    input logic eq,
                                    input logic [31:0] pc,
                                    output exp_t e,
                                    output logic [31:0] npc);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    bit addi, add, beq, bne, wr;
    int bimm;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    rd   = ins[11:7];
    addi = (opc == 7'h13) && (f3 == 3'd0);
    add  = (opc == 7'h33) && (f3 == 3'd0) && (f7 == 7'd0);
    beq  = (opc == 7'h63) && (f3 == 3'd0);
    bne  = (opc == 7'h63) && (f3 == 3'd1);
    bimm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
           + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    e.halts = 1'b0;
    e.ill   = 1'b0;
    e.vec   = '0;
    npc     = pc + 32'd4;
    if (ins == 32'h0000_0073) begin
      e.halts = 1'b1;
      npc     = pc;
    end else if (!(addi || add || beq || bne)) begin
      e.halts = 1'b1;
      e.ill   = 1'b1;
      npc     = pc;
    end else begin
      wr = (addi || add) && (rd != 5'd0);
      e.vec = {ins[19:15], ins[24:20],
               (addi || add) ? rd : 5'd0,
               wr, addi,
               addi ? ins[31:20] : 12'd0,
               (beq || bne) ? 3'b001 : 3'b000};
      if ((beq && eq) || (bne && !eq)) npc = pc + 32'(bimm);
    end
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 7);
    if (k < 3) begin
      r[6:0]   = 7'h13;
      r[14:12] = 3'd0;
    end else if (k < 5) begin
      r[6:0]   = 7'h33;
      r[14:12] = 3'd0;
      r[31:25] = 7'd0;
    end else if (k < 6) begin
      r[6:0]   = 7'h63;
      r[14:12] = 3'd0;
    end else begin
      r[6:0]   = 7'h63;
      r[14:12] = 3'd1;
    end
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  task automatic add_prog(input logic [31:0] ins, input logic eq,
                          input logic [3:0] dly, input logic hang);
    prog_t p;
    p.ins  = ins;
    p.eq   = eq;
    p.dly  = dly;
    p.hang = hang;
    prog_q.push_back(p);
  endtask

  // instruction memory: answers each fetch after its programmed delay
  initial begin : responder
    prog_t       cur;
    bit          have;
    int          cnt;
    exp_t        e;
    logic [31:0] npc;
    have      = 0;
    cnt       = 0;
    imem_ack  = 1'b0;
    imem_data = '0;
    EQ        = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        have     = 0;
        imem_ack = 1'b0;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
      end else if (imem_req) begin
        if (!have && prog_q.size() > 0) begin
          cur  = prog_q.pop_front();
          have = 1;
          cnt  = 0;
        end
        if (have && !cur.hang) begin
          if (cnt == int'(cur.dly)) begin
            ref_model(cur.ins, cur.eq, model_pc, e, npc);
            exp_q.push_back(e);
            if (!e.halts) begin
              addr_q.push_back(npc);
              exp_ret++;
            end
            model_pc  = npc;
            imem_data = cur.ins;
            EQ        = cur.eq;
            imem_ack  = 1'b1;
            have      = 0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  // monitor: fetch addresses, decode quietness, EXEC outputs, halts
  initial begin : monitor
    int          ph;
    logic        prev_req;
    exp_t        e;
    logic [31:0] a;
    ph       = 0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph       = 0;
        prev_req = 1'b0;
      end else begin
        if (WE3) we3_seen = 1'b1;
        if (ph == 2) begin
          if (exp_q.size() == 0) begin
            check("exp_queue_underflow", 96'd1, 96'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.halts)
              check("halt_state",
                    {halted, illegal, busy, imem_req, WE3},
                    {1'b1, e.ill, 1'b0, 1'b0, 1'b0});
            else
              check("exec_outputs",
                    {busy, halted, imem_req,
                     AD1, AD2, AD3, WE3, ALUsrc, ImmOP, ALUCtrl},
                    {1'b1, 1'b0, 1'b0, e.vec});
          end
          ph = 0;
        end else if (ph == 1) begin
          check("decode_outputs",
                {busy, imem_req,
                 AD1, AD2, AD3, WE3, ALUsrc, ImmOP, ALUCtrl},
                {1'b1, 1'b0, 32'd0});
          ph = 2;
        end
        if (imem_req && !prev_req) begin
          if (addr_q.size() == 0) begin
            check("addr_queue_underflow", 96'd1, 96'd0);
          end else begin
            a = addr_q.pop_front();
            check("fetch_addr", imem_addr, a);
          end
        end
        if (imem_req && imem_ack) ph = 1;
        prev_req = imem_req;
      end
    end
  end

  task automatic clear_model();
    prog_q.delete();
    exp_q.delete();
    addr_q.delete();
    model_pc = '0;
    exp_ret  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst   = 1'b1;
    start = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic go();
    addr_q.push_back(model_pc);
    start = 1'b1;
    @(negedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_halt(input int lim);
    for (int i = 0; i < lim && !halted; i++) @(negedge clk);
    #2;
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic check_instret();
`ifdef SEQ_RETIRE_CNT_EN
    check("instret", instret, exp_ret);
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    rst      = 1'b1;
    start    = 1'b0;
    we3_seen = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs",
          {imem_req, imem_addr, AD1, AD2, AD3, WE3, ALUsrc,
           ImmOP, ALUCtrl, busy, halted, illegal},
          '0);
    check_instret();
    rst = 1'b0;

    // ADDI with delayed ack, rd=0 ADDI, BNE both ways, ECALL
    add_prog(32'h0050_0513, 1'b0, 4'd2, 1'b0);
    add_prog(32'h0010_0013, 1'b0, 4'd0, 1'b0);
    add_prog(32'hFE05_1EE3, 1'b0, 4'd1, 1'b0);
    add_prog(32'h0010_0013, 1'b0, 4'd0, 1'b0);
    add_prog(32'hFE05_1EE3, 1'b1, 4'd0, 1'b0);
    add_prog(32'h0000_0073, 1'b0, 4'd0, 1'b0);
    go();
    wait_halt(200);
    check("ecall_flags", {halted, illegal, busy}, 3'b100);
    check("directed_retired", exp_ret, 5);
    check_instret();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("start_in_halt", {imem_req, halted}, 2'b01);
    end
    start = 1'b0;
    check("scoreboard_drained", exp_q.size() + addr_q.size(), 0);

    // unsupported load halts as illegal without any write
    do_reset();
    we3_seen = 1'b0;
    add_prog(32'h0000_2003, 1'b0, 4'd1, 1'b0);
    go();
    wait_halt(50);
    check("illegal_flags", {halted, illegal, busy}, 3'b110);
    check("illegal_no_we3", we3_seen, 1'b0);
    check_instret();

    // reset while a fetch is outstanding
    do_reset();
    add_prog(32'h0000_0000, 1'b0, 4'd0, 1'b1);
    go();
    repeat (2) @(negedge clk);
    #2;
    check("mid_fetch_req", {imem_req, busy}, 2'b11);
    rst = 1'b1;
    #1;
    check("reset_mid_fetch",
          {imem_req, imem_addr, busy, halted, WE3}, '0);
    clear_model();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    add_prog(32'h0050_0513, 1'b0, 4'd0, 1'b0);
    add_prog(32'h0000_0073, 1'b0, 4'd0, 1'b0);
    go();
    wait_halt(50);
    check("refetch_flags", {halted, illegal}, 2'b10);
    check_instret();

    // random program of supported instructions ending in ECALL
    do_reset();
    for (int i = 0; i < 150; i++)
      add_prog(rand_ins(), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 3)), 1'b0);
    add_prog(32'h0000_0073, 1'b0, 4'd0, 1'b0);
    go();
    wait_halt(3000);
    check("random_flags", {halted, illegal, busy}, 3'b100);
    check("random_retired", exp_ret, 150);
    check_instret();
    check("random_drained", exp_q.size() + addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The block SHALL have these parameters: ADDRESS_WIDTH, default 5, register address width; DATA_WIDTH, default 32, instruction word width; IMM_LENGTH, default 12, ImmOP width; ALU_CONTROL_LENGTH, default 3, ALUCtrl width; PC_WIDTH, default 32, program counter width.
REQ-002 The block SHALL use one clock, clk, and an asynchronous active-high reset, rst.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins execution from IDLE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address (current PC).
- imem_ack  in  1  fetch data valid.
- imem_data  in  DATA_WIDTH  fetched instruction.
- AD1, AD2, AD3  out  ADDRESS_WIDTH each  register file addresses (rs1, rs2, rd).
- WE3  out  1  register file write enable.
- ALUsrc  out  1  ALU operand-2 select (1 = immediate).
- ImmOP  out  IMM_LENGTH  immediate operand.
- ALUCtrl  out  ALU_CONTROL_LENGTH  ALU operation.
- EQ  in  1  ALU equality flag.
- busy  out  1  executing.
- halted  out  1  stopped.
- illegal  out  1  halt was caused by an unsupported instruction.

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC and HALT; all other outputs SHALL be driven from state and registers only.
REQ-005 In IDLE, start=1 SHALL move the FSM to FETCH on the next edge; start SHALL be ignored in every other state.
REQ-006 In FETCH:
- imem_req=1 and imem_addr=pc, held stable until imem_ack=1.
- On ack, imem_data SHALL be latched into IR and the FSM SHALL go to DECODE.
- imem_req SHALL drop in the cycle after ack.
- imem_ack outside FETCH SHALL be ignored.
REQ-007 DECODE SHALL last one cycle. Outcomes:
- 0x00000073 (ECALL) -> HALT with illegal=0.
- Any instruction other than ADDI, ADD (funct7=0), BEQ or BNE -> HALT with illegal=1.
- Otherwise -> EXEC.
REQ-008 EXEC SHALL last exactly one cycle, driving AD1=IR[19:15] and AD2=IR[24:20].
- ADDI: ALUsrc=1, ImmOP=IR[31:20], ALUCtrl=000.
- ADD: ALUsrc=0, ALUCtrl=000.
- Both: AD3=IR[11:7], WE3=1, except WE3=0 when rd=0.
REQ-009 For BEQ/BNE in EXEC:
- ALUsrc=0, ALUCtrl=001, WE3=0; EQ is sampled in this cycle.
- Taken = (BEQ and EQ) or (BNE and not EQ).
REQ-010 At the end of EXEC:
- pc SHALL become pc + sign-extended 13-bit B-immediate if the branch is taken, else pc+4.
- pc SHALL wrap modulo 2^PC_WIDTH.
- The FSM SHALL return to FETCH.
REQ-011 Outside EXEC, WE3, ALUsrc, ImmOP, ALUCtrl, AD1, AD2 and AD3 SHALL be 0.
REQ-012 busy SHALL be 1 in FETCH, DECODE and EXEC; halted SHALL be 1 only in HALT.
REQ-013 HALT SHALL be exited only by rst.
REQ-014 Minimum instruction latency SHALL be 3 cycles: FETCH with ack in its first cycle, then DECODE, then EXEC.

Reset
REQ-015 rst SHALL take effect immediately, including mid-fetch or mid-EXEC, forcing:
- State IDLE, pc=0, IR=0.
- Every output 0, including imem_req and WE3.
- Any pending fetch abandoned.

Configuration
REQ-016 With SEQ_RETIRE_CNT_EN defined:
- Output instret (32 bits) SHALL count completed EXEC cycles.
- instret SHALL reset to 0, wrap at 2^32, and not count halting instructions.
- Without the macro, the port and its counter SHALL be absent.

Structure
REQ-017 Package seq_pkg SHALL hold:
- The state enum.
- Opcode constants OP_IMM=0010011, OP=0110011, BRANCH=1100011.
- funct3 constants.
- ALU_ADD=3'b000 and ALU_SUB=3'b001.
- The ECALL constant.
REQ-018 Decode of IR SHALL be a combinational sub-module, seq_decoder, producing the instruction class, register fields, I-immediate and B-immediate.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADDI: addi x10,x0,5 (0x00500513), ack 2 cycles after req -> in EXEC WE3=1, AD3=10, ALUsrc=1, ImmOP=5, ALUCtrl=000; then pc=4, imem_addr=4.
- BNE: bne x10,x0,-4 (0xFE051EE3) at pc=8 -> EQ=0 gives next pc=4; EQ=1 gives next pc=12; WE3=0 throughout.
- ECALL: 0x00000073 -> halted=1, illegal=0, busy=0; a later start=1 causes no imem_req.
- Illegal: 0x00002003 (lw) -> halted=1, illegal=1, WE3 never asserted.
- Reset mid-fetch: rst during FETCH with no ack -> imem_req=0 in the same cycle, pc=0, state IDLE; start then fetches from address 0.
- rd=0 / retire count: addi x0,x0,1 (0x00100013) -> WE3 stays 0; with SEQ_RETIRE_CNT_EN, instret increments by 1 per executed instruction.
